// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit for EX.
// Shift-add multiplier and restoring divider sequenced by a 3-state FSM.
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            Stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t             state;
  logic [2:0]         op;
  logic [CNT_W-1:0]   count;
  logic [2*XLEN-1:0]  acc;
  logic [2*XLEN-1:0]  mcand;
  logic [XLEN-1:0]    mplier;
  logic               neg_lo;
  logic               neg_hi;

  logic               is_div;
  logic               a_signed;
  logic               b_signed;
  logic               a_neg;
  logic               b_neg;
  logic [XLEN-1:0]    mag_a;
  logic [XLEN-1:0]    mag_b;
  logic               fast;
  logic [XLEN-1:0]    fast_val;

  logic [2*XLEN-1:0]  mul_nxt;
  logic [XLEN:0]      rem_sh;
  logic [XLEN:0]      diff;
  logic [2*XLEN-1:0]  div_nxt;
  logic [2*XLEN-1:0]  acc_nxt;
  logic [2*XLEN-1:0]  prod;
  logic [XLEN-1:0]    quo;
  logic [XLEN-1:0]    rem;
  logic [XLEN-1:0]    final_val;

  // Operand decode, magnitudes and divide fast-path detection
  always_comb begin
    is_div   = Funct3[2];
    a_signed = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
               (Funct3 == 3'b100) || (Funct3 == 3'b110);
    b_signed = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
               (Funct3 == 3'b110);
    a_neg    = a_signed && SrcA[XLEN-1];
    b_neg    = b_signed && SrcB[XLEN-1];
    mag_a    = a_neg ? (~SrcA + 1'b1) : SrcA;
    mag_b    = b_neg ? (~SrcB + 1'b1) : SrcB;
    fast     = 1'b0;
    fast_val = '0;
    if (is_div && SrcB == '0) begin
      fast     = 1'b1;
      fast_val = Funct3[1] ? SrcA : ONES;
    end else if (is_div && !Funct3[0] &&
                 SrcA == MINV && SrcB == ONES) begin
      fast     = 1'b1;
      fast_val = Funct3[1] ? '0 : MINV;
    end
  end

  // One multiply or divide iteration plus sign-corrected final value
  always_comb begin
    mul_nxt = acc;
    if (mplier[count[4:0]])
      mul_nxt = acc + (mcand << count);
    rem_sh  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = rem_sh - {1'b0, mcand[XLEN-1:0]};
    if (diff[XLEN])
      div_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    else
      div_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    acc_nxt = op[2] ? div_nxt : mul_nxt;
    prod    = neg_lo ? (~acc_nxt + 1'b1) : acc_nxt;
    quo     = neg_lo ? (~acc_nxt[XLEN-1:0] + 1'b1)
                     : acc_nxt[XLEN-1:0];
    rem     = neg_hi ? (~acc_nxt[2*XLEN-1:XLEN] + 1'b1)
                     : acc_nxt[2*XLEN-1:XLEN];
    case (op)
      3'b000:                 final_val = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_val = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_val = quo;
      default:                final_val = rem;
    endcase
  end

  // Pipeline hold: accepted start or operation in flight
  always_comb begin
    Stall = (state == IDLE && start && !flush) || (state == RUN);
  end

  // Sequencer FSM with registered busy/done/Result
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      op     <= '0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      Result <= '0;
    end else begin
      case (state)
        IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start && !flush) begin
            op <= Funct3;
            if (fast) begin
              state  <= DONE;
              done   <= 1'b1;
              Result <= fast_val;
            end else begin
              state  <= RUN;
              busy   <= 1'b1;
              count  <= '0;
              acc    <= is_div ? {{XLEN{1'b0}}, mag_a} : '0;
              mcand  <= {{XLEN{1'b0}}, is_div ? mag_b : mag_a};
              mplier <= mag_b;
              neg_lo <= a_neg ^ b_neg;
              neg_hi <= a_neg;
            end
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (count == LAST) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              Result <= final_val;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
